hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS32 core. Shadows rd/rs/rt/control of ID/EX, EX/MEM and MEM/WB.
//  Drives Forward_A/Forward_B select codes for the EX-stage operand forwarding muxes.
//  Detects load-use hazards, taken-branch flushes and multi-cycle MULDIV occupancy.
//  Issues PC/IF-ID write enables, bubble and flush controls to the pipeline registers.
// PARAMETERS
//  MULDIV_CYCLES  32  EX-stage occupancy of a MULT/DIV instruction, in cycles (>=2)
// PORTS
//  Clk             in   1  pipeline clock, rising edge
//  Reset_n         in   1  asynchronous, active-low reset
//  Rs_ID           in   5  rs field of the instruction in ID
//  Rt_ID           in   5  rt field of the instruction in ID
//  Use_Rs_ID       in   1  instruction in ID reads rs
//  Use_Rt_ID       in   1  instruction in ID reads rt
//  Write_Reg_ID    in   5  destination register of the instruction in ID (after RegDst)
//  Reg_Write_ID    in   1  instruction in ID writes the register file
//  Mem_Read_ID     in   1  instruction in ID is a load
//  MulDiv_ID       in   1  instruction in ID is MULT/MULTU/DIV/DIVU
//  Branch_Taken_EX in   1  branch/jump resolved taken in EX this cycle
//  Forward_A       out  2  00 = register file, 10 = ALU_Result_MEM, 01 = Write_Data_WB (11 never driven)
//  Forward_B       out  2  same encoding as Forward_A, for operand B
//  PC_Write        out  1  PC load enable
//  IF_ID_Write     out  1  IF/ID load enable
//  ID_EX_Bubble    out  1  load a NOP into ID/EX on the next edge
//  IF_ID_Flush     out  1  squash IF/ID on the next edge
//  MulDiv_Busy     out  1  MULDIV unit occupying EX
// BEHAVIOUR
//  - Reset (async): all shadow valid bits cleared, Forward_A/B = 00, PC_Write = IF_ID_Write = 1,
//    ID_EX_Bubble = IF_ID_Flush = 0, FSM IDLE, counter 0. Reset mid-MULDIV aborts to IDLE.
//  - Shadow registers: advance ID->EX->MEM->WB on every edge unless held or bubbled.
//    A bubble clears valid. Register $0 is never a hazard source.
//  - Forward_A/B are registered: computed on the edge the ID instruction enters EX.
//    Compare each used rs/rt against the current EX entry (becomes MEM) and the current MEM entry (becomes WB).
//    Both entries must be valid with reg_write = 1. EX match -> 10 (wins over MEM); MEM match -> 01; else 00.
//    A load's EX match never arises because the load-use stall inserts a bubble first.
//  - Load-use stall (combinational, IDLE only):
//    condition: EX.valid & EX.mem_read & EX.rd != 0 & ((Use_Rs_ID & rd == Rs_ID) | (Use_Rt_ID & rd == Rt_ID)).
//    Response: PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1 for exactly one cycle.
//  - Branch flush (IDLE only): Branch_Taken_EX -> IF_ID_Flush = 1, ID_EX_Bubble = 1, PC_Write = 1.
//    The flush beats a simultaneous load-use stall: the stalled instruction is squashed, no stall is issued.
//  - MULDIV FSM, IDLE/BUSY:
//    IDLE->BUSY on the edge a valid MulDiv_ID instruction enters EX; counter loads MULDIV_CYCLES-1.
//    In BUSY: MulDiv_Busy = 1, PC_Write = 0, IF_ID_Write = 0, EX shadow held, EX->MEM passes a bubble.
//    The counter decrements each cycle; at 0 the FSM returns to IDLE and the EX entry advances normally.
//    The MULDIV unit latches its operands in the first BUSY cycle, so Forward_A/B drop to 00 after that cycle.
//    Branch_Taken_EX and the load-use check are ignored in BUSY.
//  - MEM/WB drain normally during all stalls.
// STRUCTURE
//  - Shared pkg mips_pipe_pkg: FWD_ORIG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10; REG_ZERO; typedef stage_info_t
//    {valid, reg_write, mem_read, rd[4:0], rs[4:0], rt[4:0], use_rs, use_rt}.
//  - One sub-module, fwd_compare: a pure function of {rs, use, EX entry, MEM entry} -> 2-bit code.
//    Instantiated twice, once for A and once for B.
// TESTING
//  1. add $3,$1,$2 then sub $4,$3,$5 -> Forward_A = 10, Forward_B = 00 in sub's EX cycle.
//  2. add $3; nop; or $6,$7,$3 -> Forward_B = 01. The same sequence with $0 as destination -> 00.
//  3. lw $2,0($1) then add $4,$2,$2 -> one cycle of PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1;
//     add then sees Forward_A = Forward_B = 01.
//  4. Load-use on the ID instruction and Branch_Taken_EX = 1 in the same cycle -> IF_ID_Flush = 1,
//     ID_EX_Bubble = 1, PC_Write = 1.
//  5. MULT with MULDIV_CYCLES = 4 -> MulDiv_Busy high for exactly 4 cycles, PC frozen, 4 bubbles into MEM;
//     Reset_n pulsed in cycle 2 -> all outputs at reset values immediately, FSM IDLE.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS32 pipeline hazard/forwarding logic.
// Provides forward-select codes, the zero register index and the stage shadow record.
package mips_pipe_pkg;

    localparam logic [1:0] FWD_ORIG = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } stage_info_t;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_compare.sv
// Forward-select decode for one EX operand.
// Ports: src/use_src (ID operand), ex_e/mem_e (shadow entries) -> fwd (select code).
module fwd_compare
    import mips_pipe_pkg::*;
(
    input  logic [4:0]  src,
    input  logic        use_src,
    input  stage_info_t ex_e,
    input  stage_info_t mem_e,
    output logic [1:0]  fwd
);

    logic ex_hit;
    logic mem_hit;
    logic unused_ok;

    assign ex_hit = use_src && (src != REG_ZERO) && ex_e.valid
                    && ex_e.reg_write && (ex_e.rd == src);

    assign mem_hit = use_src && (src != REG_ZERO) && mem_e.valid
                     && mem_e.reg_write && (mem_e.rd == src);

    // The younger (EX) producer holds the newer value, so it wins.
    always_comb begin
        fwd = FWD_ORIG;
        if (ex_hit) begin
            fwd = FWD_MEM;
        end else if (mem_hit) begin
            fwd = FWD_WB;
        end
    end

    assign unused_ok = ^{ex_e.mem_read, ex_e.rs, ex_e.rt,
                         ex_e.use_rs, ex_e.use_rt,
                         mem_e.mem_read, mem_e.rs, mem_e.rt,
                         mem_e.use_rs, mem_e.use_rt};

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage MIPS32 core: forwarding, load-use stall,
// branch flush and MULT/DIV occupancy. Ports: ID fields in; fwd selects and pipe controls out.
module hazard_forward_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       Use_Rs_ID,
    input  logic       Use_Rt_ID,
    input  logic [4:0] Write_Reg_ID,
    input  logic       Reg_Write_ID,
    input  logic       Mem_Read_ID,
    input  logic       MulDiv_ID,
    input  logic       Branch_Taken_EX,
    output logic [1:0] Forward_A,
    output logic [1:0] Forward_B,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       ID_EX_Bubble,
    output logic       IF_ID_Flush,
    output logic       MulDiv_Busy
);

    localparam int CW = $clog2(MULDIV_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t   state;
    logic [CW-1:0] cnt;
    logic        busy_q;

    stage_info_t id_info;
    stage_info_t ex_q;
    stage_info_t mem_q;
    stage_info_t wb_q;

    logic [1:0]  fwd_a_d;
    logic [1:0]  fwd_b_d;
    logic [1:0]  fwd_a_q;
    logic [1:0]  fwd_b_q;

    logic        load_use;
    logic        flush;
    logic        stall;
    logic        bubble;
    logic        enter_ex;
    logic        unused_ok;

    always_comb begin
        id_info           = '0;
        id_info.valid     = 1'b1;
        id_info.reg_write = Reg_Write_ID;
        id_info.mem_read  = Mem_Read_ID;
        id_info.rd        = Write_Reg_ID;
        id_info.rs        = Rs_ID;
        id_info.rt        = Rt_ID;
        id_info.use_rs    = Use_Rs_ID;
        id_info.use_rt    = Use_Rt_ID;
    end

    assign load_use = !busy_q && ex_q.valid && ex_q.mem_read
                      && (ex_q.rd != REG_ZERO)
                      && ((Use_Rs_ID && (ex_q.rd == Rs_ID))
                       || (Use_Rt_ID && (ex_q.rd == Rt_ID)));

    // A taken branch squashes the ID instruction, so its stall is moot.
    assign flush    = !busy_q && Branch_Taken_EX;
    assign stall    = load_use && !flush;
    assign bubble   = flush || stall;
    assign enter_ex = !busy_q && !bubble;

    assign PC_Write     = !busy_q && !stall;
    assign IF_ID_Write  = !busy_q && !stall;
    assign ID_EX_Bubble = bubble;
    assign IF_ID_Flush  = flush;
    assign MulDiv_Busy  = busy_q;
    assign Forward_A    = fwd_a_q;
    assign Forward_B    = fwd_b_q;

    fwd_compare u_fwd_a (
        .src     (Rs_ID),
        .use_src (Use_Rs_ID),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .fwd     (fwd_a_d)
    );

    fwd_compare u_fwd_b (
        .src     (Rt_ID),
        .use_src (Use_Rt_ID),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .fwd     (fwd_b_d)
    );

    // Shadow pipeline and registered forward selects.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_ORIG;
            fwd_b_q <= FWD_ORIG;
        end else begin
            wb_q <= mem_q;
            if (busy_q) begin
                // MULDIV owns EX; operands were latched in the first busy cycle.
                mem_q   <= '0;
                fwd_a_q <= FWD_ORIG;
                fwd_b_q <= FWD_ORIG;
            end else begin
                mem_q <= ex_q;
                if (bubble) begin
                    ex_q    <= '0;
                    fwd_a_q <= FWD_ORIG;
                    fwd_b_q <= FWD_ORIG;
                end else begin
                    ex_q    <= id_info;
                    fwd_a_q <= fwd_a_d;
                    fwd_b_q <= fwd_b_d;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enter_ex && MulDiv_ID) begin
                        state  <= BUSY;
                        cnt    <= CNT_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign unused_ok = ^wb_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with MULDIV_CYCLES = 4.
// Drives ID fields after each edge and checks against hand-derived values.
module tb_hazard_forward_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic [4:0] Rs_ID;
    logic [4:0] Rt_ID;
    logic       Use_Rs_ID;
    logic       Use_Rt_ID;
    logic [4:0] Write_Reg_ID;
    logic       Reg_Write_ID;
    logic       Mem_Read_ID;
    logic       MulDiv_ID;
    logic       Branch_Taken_EX;
    logic [1:0] Forward_A;
    logic [1:0] Forward_B;
    logic       PC_Write;
    logic       IF_ID_Write;
    logic       ID_EX_Bubble;
    logic       IF_ID_Flush;
    logic       MulDiv_Busy;

    int errors = 0;
    int checks = 0;

    hazard_forward_ctrl #(.MULDIV_CYCLES(4)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Rs_ID           (Rs_ID),
        .Rt_ID           (Rt_ID),
        .Use_Rs_ID       (Use_Rs_ID),
        .Use_Rt_ID       (Use_Rt_ID),
        .Write_Reg_ID    (Write_Reg_ID),
        .Reg_Write_ID    (Reg_Write_ID),
        .Mem_Read_ID     (Mem_Read_ID),
        .MulDiv_ID       (MulDiv_ID),
        .Branch_Taken_EX (Branch_Taken_EX),
        .Forward_A       (Forward_A),
        .Forward_B       (Forward_B),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Bubble    (ID_EX_Bubble),
        .IF_ID_Flush     (IF_ID_Flush),
        .MulDiv_Busy     (MulDiv_Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic id(input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt,
                      input logic [4:0] rd, input logic rw,
                      input logic mr, input logic md);
        Rs_ID        = rs;
        Rt_ID        = rt;
        Use_Rs_ID    = urs;
        Use_Rt_ID    = urt;
        Write_Reg_ID = rd;
        Reg_Write_ID = rw;
        Mem_Read_ID  = mr;
        MulDiv_ID    = md;
        #1;
    endtask

    task automatic nop();
        id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input int pcw, input int ifw,
                            input int bub, input int fl, input int busy);
        chk({tag, ".pc_write"}, PC_Write, pcw);
        chk({tag, ".if_id_write"}, IF_ID_Write, ifw);
        chk({tag, ".bubble"}, ID_EX_Bubble, bub);
        chk({tag, ".flush"}, IF_ID_Flush, fl);
        chk({tag, ".busy"}, MulDiv_Busy, busy);
    endtask

    initial begin
        Reset_n         = 1'b0;
        Branch_Taken_EX = 1'b0;
        nop();
        #12;
        chk("rst.fwd_a", Forward_A, 0);
        chk("rst.fwd_b", Forward_B, 0);
        chk_ctrl("rst", 1, 1, 0, 0, 0);
        Reset_n = 1'b1;
        tick();

        // add $3,$1,$2 ; sub $4,$3,$5
        id(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
        tick();
        id(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0);
        tick();
        chk("t1.fwd_a", Forward_A, 2);
        chk("t1.fwd_b", Forward_B, 0);

        // add $3 ; nop ; or $6,$7,$3
        id(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
        tick();
        nop();
        tick();
        id(5'd7, 5'd3, 1, 1, 5'd6, 1, 0, 0);
        tick();
        chk("t2.fwd_a", Forward_A, 0);
        chk("t2.fwd_b", Forward_B, 1);

        // add $0 ; nop ; or $6,$7,$0
        id(5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);
        tick();
        nop();
        tick();
        id(5'd7, 5'd0, 1, 1, 5'd6, 1, 0, 0);
        tick();
        chk("t2z.fwd_b", Forward_B, 0);

        // lw $2,0($1) ; add $4,$2,$2
        id(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
        tick();
        id(5'd2, 5'd2, 1, 1, 5'd4, 1, 0, 0);
        chk_ctrl("t3.stall", 0, 0, 1, 0, 0);
        tick();
        chk_ctrl("t3.after", 1, 1, 0, 0, 0);
        chk("t3.bub_fwd_a", Forward_A, 0);
        tick();
        chk("t3.fwd_a", Forward_A, 1);
        chk("t3.fwd_b", Forward_B, 1);

        // lw $2 ; add uses $2 with a taken branch in EX
        id(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
        tick();
        id(5'd2, 5'd2, 1, 1, 5'd4, 1, 0, 0);
        Branch_Taken_EX = 1'b1;
        #1;
        chk_ctrl("t4.flush", 1, 1, 1, 1, 0);
        tick();
        Branch_Taken_EX = 1'b0;
        nop();
        chk("t4.fwd_a", Forward_A, 0);
        chk_ctrl("t4.after", 1, 1, 0, 0, 0);

        // add $1 ; mult $1,$2 occupying EX for 4 cycles
        id(5'd5, 5'd6, 1, 1, 5'd1, 1, 0, 0);
        tick();
        id(5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1);
        tick();
        nop();
        chk("t5.fwd_a_first", Forward_A, 2);
        for (int i = 0; i < 4; i++) begin
            chk_ctrl($sformatf("t5.busy%0d", i), 0, 0, 0, 0, 1);
            if (i == 1) chk("t5.fwd_a_drop", Forward_A, 0);
            tick();
        end
        chk_ctrl("t5.done", 1, 1, 0, 0, 0);
        tick();

        // reset in the second busy cycle
        id(5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1);
        tick();
        nop();
        chk("t5r.busy1", MulDiv_Busy, 1);
        tick();
        chk("t5r.busy2", MulDiv_Busy, 1);
        Reset_n = 1'b0;
        #1;
        chk_ctrl("t5r.rst", 1, 1, 0, 0, 0);
        chk("t5r.fwd_a", Forward_A, 0);
        chk("t5r.fwd_b", Forward_B, 0);
        #2;
        Reset_n = 1'b1;
        tick();
        chk_ctrl("t5r.idle", 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
